// File: rtl/access_arbiter_if.sv
// Bundle of request/grant/resource signals between four requesters and access_arbiter.
interface access_arbiter_if;
    // Handshake: req[i] is a level held for the whole session. grant is registered and one-hot.
    // confirm[g] and user code g are sampled only while the grant is pending. Dropping req[g] ends the session.
    logic [3:0]  req;
    logic [3:0]  confirm;
    logic [31:0] user_bus;
    logic [3:0]  grant;
    logic        regP;
    logic        regQ;
    logic        busy;
    logic        fail;
    logic [3:0]  locked;

    modport master (output req, confirm, user_bus,
                    input  grant, regP, regQ, busy, fail, locked);
    modport slave  (input  req, confirm, user_bus,
                    output grant, regP, regQ, busy, fail, locked);
endinterface

// File: rtl/access_arbiter.sv
// Round-robin password-gated arbiter granting four requesters access to resource P or Q.
// Optional macro ACCESS_ARBITER_LOCKOUT_EN locks out a requester after three denied accesses.
module access_arbiter #(
    parameter logic [7:0]  PASSWORD = 8'b00000011,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic            clock,
    input  logic            reset,
    access_arbiter_if.slave bus,
    output logic [1:0]      state_dbg
);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACTIVE = 2'd2, DENY = 2'd3} state_t;

    state_t          state_q, state_d;
    logic [3:0]      grant_q, grant_d;
    logic [1:0]      g_q, g_d;
    logic [1:0]      last_q, last_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            regp_q, regp_d;
    logic            regq_q, regq_d;
    logic            fail_q, fail_d;
    logic            busy_q;
    logic            run_q;
    logic            cnt_clr, cnt_inc;
    logic [3:0]      locked_w;
    logic [3:0]      eligible;
    logic [1:0]      sel;
    logic            found;
    logic [7:0]      user_g;

    assign eligible = bus.req & ~locked_w;
    assign user_g   = bus.user_bus[{g_q, 3'b000} +: 8];

    // Search starts one past the last served requester; offset 4 wraps back to it last.
    always_comb begin
        sel   = last_q;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!found && eligible[last_q + 2'(k)]) begin
                sel   = last_q + 2'(k);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        g_d     = g_q;
        regp_d  = regp_q;
        regq_d  = regq_q;
        fail_d  = 1'b0;
        timer_d = timer_q;
        last_d  = last_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                regp_d  = 1'b0;
                regq_d  = 1'b0;
                if (run_q && found) begin
                    state_d = WAIT;
                    grant_d = 4'b0001 << sel;
                    g_d     = sel;
                    timer_d = '0;
                end
            end
            WAIT: begin
                timer_d = timer_q + TW'(1);
                // Bit 7 picks the resource, so only the low seven bits form the access code.
                if (!bus.req[g_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = g_q;
                end else if (bus.confirm[g_q] && user_g[6:0] == PASSWORD[6:0]) begin
                    state_d = ACTIVE;
                    regp_d  = ~user_g[7];
                    regq_d  = user_g[7];
                    last_d  = g_q;
                    cnt_clr = 1'b1;
                end else if (bus.confirm[g_q] || timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = DENY;
                    grant_d = '0;
                    fail_d  = 1'b1;
                    last_d  = g_q;
                end
            end
            ACTIVE: begin
                if (!bus.req[g_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    regp_d  = 1'b0;
                    regq_d  = 1'b0;
                end
            end
            DENY: begin
                state_d = IDLE;
                cnt_inc = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // run_q holds off arbitration for one edge after reset release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            g_q     <= 2'd0;
            last_q  <= 2'd3;
            timer_q <= '0;
            regp_q  <= 1'b0;
            regq_q  <= 1'b0;
            fail_q  <= 1'b0;
            busy_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            g_q     <= g_d;
            last_q  <= last_d;
            timer_q <= timer_d;
            regp_q  <= regp_d;
            regq_q  <= regq_d;
            fail_q  <= fail_d;
            busy_q  <= (state_d != IDLE);
            run_q   <= 1'b1;
        end
    end

`ifdef ACCESS_ARBITER_LOCKOUT_EN
    logic [1:0] fail_cnt_q [4];
    logic [3:0] locked_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) fail_cnt_q[i] <= 2'd0;
            locked_q <= '0;
        end else if (cnt_clr) begin
            fail_cnt_q[g_q] <= 2'd0;
        end else if (cnt_inc && fail_cnt_q[g_q] != 2'd3) begin
            fail_cnt_q[g_q] <= fail_cnt_q[g_q] + 2'd1;
            if (fail_cnt_q[g_q] == 2'd2) locked_q[g_q] <= 1'b1;
        end
    end

    assign locked_w = locked_q;
`else
    logic unused_cnt;
    assign unused_cnt = cnt_clr ^ cnt_inc;
    assign locked_w   = 4'b0000;
`endif

    assign bus.grant  = grant_q;
    assign bus.regP   = regp_q;
    assign bus.regQ   = regq_q;
    assign bus.busy   = busy_q;
    assign bus.fail   = fail_q;
    assign bus.locked = locked_w;
    assign state_dbg  = state_q;
endmodule

// File: tb/tb_access_arbiter.sv
// Scoreboard bench for access_arbiter: sessions push predicted output snapshots, a monitor compares them.
module tb_access_arbiter;
    localparam logic [7:0] PASSWORD = 8'b00000011;
    localparam int         TIMEOUT  = 15;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] state_dbg;

    access_arbiter_if bus();

    access_arbiter #(.PASSWORD(PASSWORD), .TIMEOUT(TIMEOUT)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [43:0] exp_q[$];   // {cycle tag, output snapshot}

    // Reference model state: last served requester, failure counts, lockout flags.
    int          m_last;
    int          m_fail_cnt[4];
    logic [3:0]  m_locked;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [11:0] dut_vec();
        return {bus.grant, bus.regP, bus.regQ, bus.busy, bus.fail, bus.locked};
    endfunction

    task automatic push_exp(input int tag, input logic [3:0] g, input logic p, input logic q,
                            input logic b, input logic f);
        exp_q.push_back({32'(tag), g, p, q, b, f, m_locked});
    endtask

    task automatic model_reset();
        m_last   = 3;
        m_locked = '0;
        for (int i = 0; i < 4; i++) m_fail_cnt[i] = 0;
    endtask

    function automatic int pick(input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (m_last + k) % 4;
            if (r[idx] && !m_locked[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_deny(input int g);
        if (m_fail_cnt[g] < 3) m_fail_cnt[g]++;
`ifdef ACCESS_ARBITER_LOCKOUT_EN
        if (m_fail_cnt[g] == 3) m_locked[g] = 1'b1;
`endif
        m_last = g;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Monitor: any change of the output snapshot must match the next expected entry and its cycle.
    logic [11:0] prev_vec = '0;
    always @(posedge clock) begin
        logic [11:0] cur;
        logic [43:0] item;
        cyc = cyc + 1;
        #2;
        cur = dut_vec();
        if (cur !== prev_vec) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_change: got %h at cycle %0d, required no change from %h", cur, cyc, prev_vec);
            end else begin
                item = exp_q.pop_front();
                check("out_vec", 32'(cur), 32'(item[11:0]));
                check("out_cycle", 32'(cyc), item[43:12]);
            end
            prev_vec = cur;
        end
    end

    // action: 0 good confirm, 1 bad confirm, 2 timeout, 3 req drop, 4 req drop with confirm
    task automatic run_session(input logic [3:0] r, input int action, input int k, input int hold,
                               input logic [7:0] code);
        int          g;
        logic [3:0]  gm;
        logic [31:0] ub;
        g  = pick(r);
        ub = $urandom;
        if (g >= 0) ub[g*8 +: 8] = code;
        bus.user_bus = ub;
        bus.req      = r;
        if (g < 0) begin
            bus.confirm = 4'($urandom);
            step(4);
            bus.req = '0;
            bus.confirm = '0;
            step(2);
            return;
        end
        gm = 4'b0001 << g;
        bus.confirm = 4'($urandom) & ~gm;
        push_exp(cyc + 1, gm, 1'b0, 1'b0, 1'b1, 1'b0);
        case (action)
            0: begin
                step(k);
                bus.confirm = bus.confirm | gm;
                push_exp(cyc + 1, gm, ~code[7], code[7], 1'b1, 1'b0);
                m_fail_cnt[g] = 0;
                m_last = g;
                step(1);
                bus.confirm = '0;
                for (int i = 0; i < hold; i++) begin
                    bus.user_bus = $urandom;
                    bus.confirm  = 4'($urandom);
                    step(1);
                end
                bus.req = '0;
                bus.confirm = '0;
                push_exp(cyc + 1, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            1, 2: begin
                step(action == 1 ? k : TIMEOUT);
                if (action == 1) bus.confirm = bus.confirm | gm;
                push_exp(cyc + 1, 4'b0, 1'b0, 1'b0, 1'b1, 1'b1);
                step(1);
                bus.req = '0;
                bus.confirm = '0;
                model_deny(g);
                push_exp(cyc + 1, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            default: begin
                step(k);
                bus.req = '0;
                if (action == 4) bus.confirm = gm;
                push_exp(cyc + 1, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                m_last = g;
                step(1);
                bus.confirm = '0;
            end
        endcase
        step(2);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        logic [7:0] code;
        int         a, k, h;

        // Reset with requester 0 already waiting: grant only on the second edge after release.
        bus.req      = 4'b0001;
        bus.confirm  = '0;
        bus.user_bus = 32'h0000_0003;
        #1 reset = 1'b0;
        model_reset();
        step(2);
        check("reset_outputs", 32'(dut_vec()), 32'h0);
        reset = 1'b1;
        push_exp(cyc + 2, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0);
        step(3);
        bus.confirm = 4'b0001;
        push_exp(cyc + 1, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0);
        m_last = 0;
        step(1);
        bus.confirm = '0;
        step(2);
        bus.req = '0;
        push_exp(cyc + 1, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2);

        // Two requesters: 1 wins (rotation after 0), then 2 gets the grant when 1 leaves.
        bus.user_bus = 32'h0003_8300;
        bus.req      = 4'b0110;
        push_exp(cyc + 1, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0);
        step(2);
        bus.confirm = 4'b0010;
        push_exp(cyc + 1, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0);
        m_last = 1;
        step(1);
        bus.confirm = '0;
        step(2);
        bus.req = 4'b0100;
        push_exp(cyc + 1, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp(cyc + 2, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0);
        step(3);
        bus.confirm = 4'b0100;
        push_exp(cyc + 1, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0);
        m_last = 2;
        step(1);
        bus.confirm = '0;
        step(2);
        bus.req = '0;
        push_exp(cyc + 1, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2);

        // Drop together with a matching confirm, then a pure timeout.
        run_session(4'b0001, 4, 2, 0, PASSWORD);
        run_session(4'b0001, 2, 0, 0, 8'h05);

        // Asynchronous reset in the middle of an ACTIVE session on resource Q.
        bus.user_bus = 32'h0000_8300;
        bus.req      = 4'b0010;
        push_exp(cyc + 1, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0);
        step(2);
        bus.confirm = 4'b0010;
        push_exp(cyc + 1, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1);
        bus.confirm = '0;
        step(2);
        @(posedge clock);
        #3;
        model_reset();
        push_exp(cyc + 1, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check("async_reset_regQ", 32'(bus.regQ), 32'h0);
        check("async_reset_grant", 32'(bus.grant), 32'h0);
        check("async_reset_busy", 32'(bus.busy), 32'h0);
        @(negedge clock);
        bus.req = '0;
        reset   = 1'b1;
        step(2);

        // Three bad codes from requester 0, then a correct attempt.
        for (int i = 0; i < 3; i++) run_session(4'b0001, 1, $urandom_range(1, TIMEOUT), 0, 8'h05);
        run_session(4'b0001, 0, 2, 1, PASSWORD);

        for (int s = 0; s < 40; s++) begin
            r    = 4'($urandom_range(1, 15));
            a    = $urandom_range(0, 4);
            k    = $urandom_range(1, TIMEOUT);
            h    = $urandom_range(0, 4);
            code = 8'($urandom);
            if (a == 0) code[6:0] = PASSWORD[6:0];
            else if (a == 1 && code[6:0] == PASSWORD[6:0]) code[0] = ~code[0];
            run_session(r, a, k, h, code);
        end

        step(4);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
